fetch_entry_queue: RTL and testbench

FETCH_ENTRY_QUEUE -- requirements
Module: fetch_entry_queue

---
 rtl/fetch_entry_queue_if.sv | 44 ++++
 rtl/fetch_entry_queue.sv | 95 +++++++++
 tb/tb_fetch_entry_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_entry_queue_if.sv
// Handshake bundle between the fetch stage, the fetch entry queue and decode.
// The queue side uses the slave modport; the fetch/decode side uses master.
interface fetch_entry_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              push_valid_i;
  logic              push_ready_o;
  logic [63:0]       push_addr_i;
  logic [31:0]       push_instr_i;
  logic              push_bp_valid_i;
  logic [63:0]       push_bp_target_i;
  logic              push_ex_valid_i;
  logic [63:0]       push_ex_cause_i;
  logic [63:0]       fetch_entry_addr_o;
  logic [31:0]       fetch_entry_instr_o;
  logic              fetch_entry_bp_valid_o;
  logic [63:0]       fetch_entry_bp_target_o;
  logic              fetch_entry_ex_valid_o;
  logic [63:0]       fetch_entry_ex_cause_o;
  logic              fetch_entry_valid_o;
  logic              fetch_ack_i;
  logic [CNT_W-1:0]  usage_o;

  modport slave (
    input  flush_i, push_valid_i, push_addr_i, push_instr_i, push_bp_valid_i,
           push_bp_target_i, push_ex_valid_i, push_ex_cause_i, fetch_ack_i,
    output push_ready_o, fetch_entry_addr_o, fetch_entry_instr_o,
           fetch_entry_bp_valid_o, fetch_entry_bp_target_o,
           fetch_entry_ex_valid_o, fetch_entry_ex_cause_o,
           fetch_entry_valid_o, usage_o
  );

  modport master (
    output flush_i, push_valid_i, push_addr_i, push_instr_i, push_bp_valid_i,
           push_bp_target_i, push_ex_valid_i, push_ex_cause_i, fetch_ack_i,
    input  push_ready_o, fetch_entry_addr_o, fetch_entry_instr_o,
           fetch_entry_bp_valid_o, fetch_entry_bp_target_o,
           fetch_entry_ex_valid_o, fetch_entry_ex_cause_o,
           fetch_entry_valid_o, usage_o
  );
endinterface

// File: rtl/fetch_entry_queue.sv
// Circular queue of fetched instruction entries between fetch and decode.
// Head fields come straight from storage; a pushed entry appears one cycle later.
module fetch_entry_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fetch_entry_queue_if.slave q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        bp_valid;
    logic [63:0] bp_target;
    logic        ex_valid;
    logic [63:0] ex_cause;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           push_entry;
  entry_t           head_entry;

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             push_fire;
  logic             pop_fire;

  // Handshake qualifiers depend on registered count only, never on ack.
  assign push_fire = q.push_valid_i && (cnt_reg != FULL);
  assign pop_fire  = q.fetch_ack_i && (cnt_reg != '0);

  assign push_entry = '{
    addr:      q.push_addr_i,
    instr:     q.push_instr_i,
    bp_valid:  q.push_bp_valid_i,
    bp_target: q.push_bp_target_i,
    ex_valid:  q.push_ex_valid_i,
    ex_cause:  q.push_ex_cause_i
  };

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    cnt_next    = cnt_reg;
    if (q.flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      cnt_next    = '0;
    end else begin
      if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   cnt_next = cnt_reg + CNT_W'(1);
        2'b01:   cnt_next = cnt_reg - CNT_W'(1);
        default: cnt_next = cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Storage is left unreset; a flushed push must not land in a slot.
  always_ff @(posedge clk_i) begin
    if (push_fire && !q.flush_i) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  assign head_entry = mem[rd_ptr_reg];

  assign q.push_ready_o            = (cnt_reg != FULL);
  assign q.fetch_entry_valid_o     = (cnt_reg != '0);
  assign q.usage_o                 = cnt_reg;
  assign q.fetch_entry_addr_o      = head_entry.addr;
  assign q.fetch_entry_instr_o     = head_entry.instr;
  assign q.fetch_entry_bp_valid_o  = head_entry.bp_valid;
  assign q.fetch_entry_bp_target_o = head_entry.bp_target;
  assign q.fetch_entry_ex_valid_o  = head_entry.ex_valid;
  assign q.fetch_entry_ex_cause_o  = head_entry.ex_cause;
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed bench for fetch_entry_queue: fill/drain, streaming, full+ack,
// flush collision, field integrity and asynchronous reset.
module tb_fetch_entry_queue;
  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  fetch_entry_queue_if #(.DEPTH(4)) bus ();

  fetch_entry_queue #(.DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .q     (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    bus.flush_i      = 1'b0;
    bus.push_valid_i = 1'b0;
    bus.fetch_ack_i  = 1'b0;
  endtask

  task automatic drive_push(input logic [63:0] a);
    bus.push_valid_i     = 1'b1;
    bus.push_addr_i      = a;
    bus.push_instr_i     = a[31:0] ^ 32'h0000_0013;
    bus.push_bp_valid_i  = 1'b0;
    bus.push_bp_target_i = a + 64'h40;
    bus.push_ex_valid_i  = 1'b0;
    bus.push_ex_cause_i  = 64'h0;
  endtask

  task automatic push_one(input logic [63:0] a);
    drive_push(a);
    bus.fetch_ack_i = 1'b0;
    $display("push addr=0x%0h", a);
    step();
    bus.push_valid_i = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [63:0] a);
    check_val({tag, "_valid"}, 64'(bus.fetch_entry_valid_o), 64'd1);
    check_val({tag, "_addr"}, bus.fetch_entry_addr_o, a);
    $display("pop  addr=0x%0h", bus.fetch_entry_addr_o);
    bus.push_valid_i = 1'b0;
    bus.fetch_ack_i  = 1'b1;
    step();
    bus.fetch_ack_i  = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    drive_push(64'h0);
    bus.push_valid_i = 1'b0;
    #1;
    check_val("rst_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    check_val("rst_ready", 64'(bus.push_ready_o), 64'd1);
    check_val("rst_usage", 64'(bus.usage_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    check_val("post_rst_usage", 64'(bus.usage_o), 64'd0);

    // Ack on an empty queue must be ignored.
    bus.fetch_ack_i = 1'b1;
    step();
    bus.fetch_ack_i = 1'b0;
    check_val("empty_ack_usage", 64'(bus.usage_o), 64'd0);

    // No combinational bypass from push to head.
    drive_push(64'h8000_0000);
    #1;
    check_val("no_bypass_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    @(negedge clk_i);
    bus.push_valid_i = 1'b0;
    check_val("latency_valid", 64'(bus.fetch_entry_valid_o), 64'd1);

    // Fill then drain; fifth push while full is dropped.
    push_one(64'h8000_0004);
    push_one(64'h8000_0008);
    push_one(64'h8000_000C);
    check_val("full_usage", 64'(bus.usage_o), 64'd4);
    check_val("full_ready", 64'(bus.push_ready_o), 64'd0);
    push_one(64'h8000_0010);
    check_val("full_ignored_usage", 64'(bus.usage_o), 64'd4);
    pop_expect("drain0", 64'h8000_0000);
    pop_expect("drain1", 64'h8000_0004);
    pop_expect("drain2", 64'h8000_0008);
    pop_expect("drain3", 64'h8000_000C);
    check_val("drained_usage", 64'(bus.usage_o), 64'd0);
    check_val("drained_valid", 64'(bus.fetch_entry_valid_o), 64'd0);

    // Streaming across pointer wrap: push and ack every cycle.
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        check_val("stream_usage", 64'(bus.usage_o), 64'd1);
        check_val("stream_addr", bus.fetch_entry_addr_o, 64'h1000 + 64'(4 * (k - 1)));
        $display("pop  addr=0x%0h", bus.fetch_entry_addr_o);
      end
      if (k < 10) begin
        drive_push(64'h1000 + 64'(4 * k));
        $display("push addr=0x%0h", bus.push_addr_i);
      end else begin
        bus.push_valid_i = 1'b0;
      end
      bus.fetch_ack_i = (k > 0);
      step();
    end
    idle();
    check_val("stream_end_usage", 64'(bus.usage_o), 64'd0);

    // Full plus ack: only the pop happens, then the push is accepted.
    push_one(64'h100);
    push_one(64'h104);
    push_one(64'h108);
    push_one(64'h10C);
    drive_push(64'h200);
    bus.fetch_ack_i = 1'b1;
    step();
    idle();
    check_val("fullack_usage", 64'(bus.usage_o), 64'd3);
    check_val("fullack_ready", 64'(bus.push_ready_o), 64'd1);
    check_val("fullack_head", bus.fetch_entry_addr_o, 64'h104);
    push_one(64'h200);
    check_val("fullack_refill", 64'(bus.usage_o), 64'd4);
    pop_expect("fa0", 64'h104);
    pop_expect("fa1", 64'h108);
    pop_expect("fa2", 64'h10C);
    pop_expect("fa3", 64'h200);

    // Flush collides with push and ack.
    push_one(64'h300);
    push_one(64'h304);
    drive_push(64'h308);
    bus.fetch_ack_i = 1'b1;
    bus.flush_i     = 1'b1;
    step();
    idle();
    check_val("flush_usage", 64'(bus.usage_o), 64'd0);
    check_val("flush_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    check_val("flush_ready", 64'(bus.push_ready_o), 64'd1);
    push_one(64'h400);
    check_val("after_flush_usage", 64'(bus.usage_o), 64'd1);
    pop_expect("after_flush", 64'h400);

    // Field integrity of an exception entry, held without ack.
    bus.push_valid_i     = 1'b1;
    bus.push_addr_i      = 64'h8000_0FFC;
    bus.push_instr_i     = 32'h0000_0013;
    bus.push_bp_valid_i  = 1'b1;
    bus.push_bp_target_i = 64'h8000_1000;
    bus.push_ex_valid_i  = 1'b1;
    bus.push_ex_cause_i  = 64'h1;
    $display("push addr=0x%0h (exception entry)", bus.push_addr_i);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      check_val("fld_instr", 64'(bus.fetch_entry_instr_o), 64'h13);
      check_val("fld_bp_valid", 64'(bus.fetch_entry_bp_valid_o), 64'd1);
      check_val("fld_bp_target", bus.fetch_entry_bp_target_o, 64'h8000_1000);
      check_val("fld_ex_valid", 64'(bus.fetch_entry_ex_valid_o), 64'd1);
      check_val("fld_ex_cause", bus.fetch_entry_ex_cause_o, 64'h1);
      step();
    end
    pop_expect("fld_pop", 64'h8000_0FFC);

    // Asynchronous reset between edges with three entries queued.
    push_one(64'h500);
    push_one(64'h504);
    push_one(64'h508);
    check_val("pre_arst_usage", 64'(bus.usage_o), 64'd3);
    #2;
    rst_i = 1'b1;
    #1;
    check_val("arst_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    check_val("arst_usage", 64'(bus.usage_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    check_val("arst_rel_ready", 64'(bus.push_ready_o), 64'd1);
    check_val("arst_rel_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    check_val("arst_rel_usage", 64'(bus.usage_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
